// File: rtl/wishbone_memory_responder_if.sv
// Wishbone B4 pipelined bus bundle shared by the CPU-side masters and memory responders.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_mosi,
    input  dat_miso, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_mosi,
    output dat_miso, ack, err, stall
  );
endinterface

// File: rtl/wishbone_memory_responder.sv
// Word-organised RAM behind a pipelined Wishbone slave port: one request at a time,
// WAIT_STATES extra cycles, then a single-cycle ack (good access) or err (bad access).
module wishbone_memory_responder #(
  parameter int unsigned SIZE_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 1,
  parameter string       INIT_FILE    = ""
) (
  input logic              clk,
  input logic              rst,
  wishbone_interface.slave wb
);

  localparam int unsigned IDX_W = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(SIZE_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;

  logic             req_we;
  logic             req_good;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]       req_sel;
  logic [31:0]      req_dat;

  logic [31:0] mem [SIZE_WORDS];

  // 33-bit offset keeps the range test free of wrap-around near the top of the map
  logic [32:0]      offset;
  logic             in_range;
  logic             aligned;
  logic             bus_good;
  logic [IDX_W-1:0] bus_idx;

  always_comb begin
    offset   = {1'b0, wb.adr} - {1'b0, BASE_ADDRESS};
    in_range = (wb.adr >= BASE_ADDRESS) && (offset < SPAN);
    aligned  = offset[1:0] == 2'b00;
    bus_good = in_range && aligned;
    bus_idx  = offset[IDX_W+1:2];
  end

  // With zero wait states the response is launched on the accept edge itself,
  // so the live bus fields stand in for the not-yet-latched request.
  logic             accept;
  logic             go_resp;
  logic             from_idle;
  logic             cur_we;
  logic             cur_good;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]       cur_sel;
  logic [31:0]      cur_dat;
  logic             commit;

  always_comb begin
    from_idle = state == S_IDLE;
    accept    = from_idle && wb.cyc && wb.stb;
    if (WAIT_STATES == 0) go_resp = accept;
    else                  go_resp = (state == S_WAIT) && wb.cyc && (count == '0);
    cur_we    = from_idle ? wb.we       : req_we;
    cur_good  = from_idle ? bus_good    : req_good;
    cur_idx   = from_idle ? bus_idx     : req_idx;
    cur_sel   = from_idle ? wb.sel      : req_sel;
    cur_dat   = from_idle ? wb.dat_mosi : req_dat;
    commit    = rst && go_resp && cur_good && cur_we;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      req_we   <= 1'b0;
      req_good <= 1'b0;
      req_idx  <= '0;
      req_sel  <= '0;
      req_dat  <= '0;
    end else begin
      ack_q <= go_resp && cur_good;
      err_q <= go_resp && !cur_good;
      dat_q <= (go_resp && cur_good && !cur_we) ? mem[cur_idx] : '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_we   <= wb.we;
            req_good <= bus_good;
            req_idx  <= bus_idx;
            req_sel  <= wb.sel;
            req_dat  <= wb.dat_mosi;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              count <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (!wb.cyc)            state <= S_IDLE;
          else if (count == '0)   state <= S_RESP;
          else                    count <= count - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wb.stall    = state != S_IDLE;
  assign wb.ack      = ack_q;
  assign wb.err      = err_q;
  assign wb.dat_miso = dat_q;

endmodule
